sb_serializer: RTL and testbench



---
 rtl/sb_serializer_if.sv | 24 ++
 rtl/sb_serializer.sv | 112 +++++++++++
 tb/tb_sb_serializer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/sb_serializer_if.sv
// Parallel-side handshake bundle for sb_serializer.
//   in_data       : WIDTH-bit message, bit 0 leaves the lane first
//   in_data_valid : producer has a message
//   in_data_ready : serializer can accept a message
// The master modport is the message producer; the slave modport is the serializer.
interface sb_serializer_if #(
  parameter int unsigned WIDTH = 128
);
  logic [WIDTH-1:0] in_data;
  logic             in_data_valid;
  logic             in_data_ready;

  modport master (
    output in_data,
    output in_data_valid,
    input  in_data_ready
  );

  modport slave (
    input  in_data,
    input  in_data_valid,
    output in_data_ready
  );
endinterface

// File: rtl/sb_serializer.sv
// Sideband transmit serializer. Takes one WIDTH-bit message per ready/valid handshake
// and shifts it out LSB first, one bit per clock, then forces GAP low idle cycles.
//   clk        : block clock, rising edge
//   rst        : synchronous, active-high reset
//   in_if      : slave side of the message handshake (in_data / valid / ready)
//   out_data   : serial bit, registered
//   out_active : high while out_data carries a message bit (sideband clock enable)
//   out_done   : one-cycle pulse on the cycle after the last message bit
module sb_serializer #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned GAP   = 32
) (
  input  logic            clk,
  input  logic            rst,
  sb_serializer_if.slave  in_if,
  output logic            out_data,
  output logic            out_active,
  output logic            out_done
);

  localparam int unsigned MaxLen = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int unsigned CntW   = $clog2(MaxLen) + 1;
  localparam logic [CntW-1:0] WidthLast = CntW'(WIDTH - 1);
  // Unused when GAP == 0: the gap state is never entered.
  localparam logic [CntW-1:0] GapLast   = (GAP > 0) ? CntW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             done_q, done_d;
  logic             data_q, data_d;
  logic             active_q, active_d;
  logic             ready;
  logic             handshake;

  // Ready is a pure decode of state and rst; valid never feeds back into it.
  assign ready               = (state_q == StIdle) && !rst;
  assign handshake           = ready && in_if.in_data_valid;
  assign in_if.in_data_ready = ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          shift_d = in_if.in_data;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == WidthLast) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = (GAP == 0) ? StIdle : StGap;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Lane outputs are computed from the next state so they are true flops and only
    // move on rising edges; the receiver samples them on the falling edge.
    active_d = (state_d == StShift);
    data_d   = active_d && shift_d[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shift_q  <= '0;
      done_q   <= 1'b0;
      data_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      done_q   <= done_d;
      data_q   <= data_d;
      active_q <= active_d;
    end
  end

  assign out_data   = data_q;
  assign out_active = active_q;
  assign out_done   = done_q;

endmodule

// File: tb/tb_sb_serializer.sv
// Directed self-checking bench for sb_serializer.
// DUT a: WIDTH=128, GAP=32. DUT b: WIDTH=8, GAP=0. Both share clk and rst.
// Outputs are sampled 1 time unit after each rising edge.
module tb_sb_serializer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sb_serializer_if #(.WIDTH(128)) a_if ();
  sb_serializer_if #(.WIDTH(8))   b_if ();

  logic a_out_data, a_out_active, a_out_done;
  logic b_out_data, b_out_active, b_out_done;

  sb_serializer #(.WIDTH(128), .GAP(32)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .in_if      (a_if),
    .out_data   (a_out_data),
    .out_active (a_out_active),
    .out_done   (a_out_done)
  );

  sb_serializer #(.WIDTH(8), .GAP(0)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .in_if      (b_if),
    .out_data   (b_out_data),
    .out_active (b_out_active),
    .out_done   (b_out_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake d on DUT a in the current cycle (cycle 0), then watch the lane until
  // ready returns. rx rebuilds the message as a falling-edge receiver gated by
  // out_active would. Cycle numbers are relative to the handshake cycle.
  task automatic run_msg(input logic [127:0] d, input bit hold,
                         output logic [127:0] rx, output int act_cycles, output int act_first,
                         output int done_at, output int done_cnt, output int ready_at,
                         output int gap_bad);
    rx = '0; act_cycles = 0; act_first = -1; done_at = -1; done_cnt = 0;
    ready_at = -1; gap_bad = 0;
    check_eq("ready_before_hs", a_if.in_data_ready, 1);
    a_if.in_data       = d;
    a_if.in_data_valid = 1'b1;
    tick();
    if (!hold) a_if.in_data_valid = 1'b0;
    a_if.in_data = ~d;  // must not disturb the message in flight
    for (int cyc = 1; cyc < 400; cyc++) begin
      if (a_out_active) begin
        rx = {a_out_data, rx[127:1]};
        act_cycles++;
        if (act_first < 0) act_first = cyc;
      end else if (a_out_data) begin
        gap_bad++;
      end
      if (a_out_done) begin
        done_at = cyc;
        done_cnt++;
      end
      if (a_if.in_data_ready) begin
        ready_at = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic check_msg(input string p, input logic [127:0] d, input logic [127:0] rx,
                           input int act_cycles, input int act_first, input int done_at,
                           input int done_cnt, input int ready_at, input int gap_bad);
    check_eq({p, "_rx"}, rx, d);
    check_eq({p, "_act_cycles"}, act_cycles, 128);
    check_eq({p, "_act_first"}, act_first, 1);
    check_eq({p, "_done_at"}, done_at, 129);
    check_eq({p, "_done_cnt"}, done_cnt, 1);
    check_eq({p, "_ready_at"}, ready_at, 161);
    check_eq({p, "_gap_low"}, gap_bad, 0);
  endtask

  logic [127:0] rx;
  int act_cycles, act_first, done_at, done_cnt, ready_at, gap_bad;

  logic [127:0] one_end;
  logic [127:0] alt;
  logic [127:0] m0, m1, m2, m4;
  logic [35:0]  hs_vec, act_vec, done_vec, hs_exp, act_exp, done_exp;
  logic [7:0]   rx1, rx2;

  initial begin
    one_end = {1'b1, 126'b0, 1'b1};
    alt     = {32{4'hA}};
    m0      = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    m1      = 128'hDEAD_BEEF_0000_FFFF_1234_5678_9ABC_DEF0;
    m2      = 128'h5555_0000_AAAA_FFFF_C3C3_3C3C_0F0F_F0F0;
    m4      = 128'hCAFE_F00D_8421_1248_0000_0001_8000_0000;

    rst = 1'b1;
    a_if.in_data = '0; a_if.in_data_valid = 1'b0;
    b_if.in_data = '0; b_if.in_data_valid = 1'b0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_ready_a", a_if.in_data_ready, 0);
    check_eq("rst_ready_b", b_if.in_data_ready, 0);
    check_eq("rst_data", a_out_data, 0);
    check_eq("rst_active", a_out_active, 0);
    check_eq("rst_done", a_out_done, 0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", a_if.in_data_ready, 1);

    // Single-bit-at-each-end message
    run_msg(one_end, 1'b0, rx, act_cycles, act_first, done_at, done_cnt, ready_at, gap_bad);
    check_msg("ends", one_end, rx, act_cycles, act_first, done_at, done_cnt, ready_at, gap_bad);
    check_eq("ends_first_bit", rx[0], 1);
    check_eq("ends_last_bit", rx[127], 1);
    tick();
    check_eq("idle_active", a_out_active, 0);
    check_eq("idle_done", a_out_done, 0);

    // Alternating pattern through the gated-clock receiver model
    run_msg(alt, 1'b0, rx, act_cycles, act_first, done_at, done_cnt, ready_at, gap_bad);
    check_msg("alt", alt, rx, act_cycles, act_first, done_at, done_cnt, ready_at, gap_bad);

    // Valid held high: three back-to-back messages, 161 cycles apart
    run_msg(m0, 1'b1, rx, act_cycles, act_first, done_at, done_cnt, ready_at, gap_bad);
    check_msg("b2b0", m0, rx, act_cycles, act_first, done_at, done_cnt, ready_at, gap_bad);
    run_msg(m1, 1'b1, rx, act_cycles, act_first, done_at, done_cnt, ready_at, gap_bad);
    check_msg("b2b1", m1, rx, act_cycles, act_first, done_at, done_cnt, ready_at, gap_bad);
    run_msg(m2, 1'b1, rx, act_cycles, act_first, done_at, done_cnt, ready_at, gap_bad);
    check_msg("b2b2", m2, rx, act_cycles, act_first, done_at, done_cnt, ready_at, gap_bad);
    a_if.in_data_valid = 1'b0;
    tick();

    // Reset 50 cycles into SHIFT, held 2 cycles
    a_if.in_data = m4; a_if.in_data_valid = 1'b1;
    tick();
    a_if.in_data_valid = 1'b0;
    repeat (49) tick();
    check_eq("mid_shift_active", a_out_active, 1);
    rst = 1'b1;
    tick();
    check_eq("rs_active", a_out_active, 0);
    check_eq("rs_data", a_out_data, 0);
    check_eq("rs_done", a_out_done, 0);
    check_eq("rs_ready", a_if.in_data_ready, 0);
    tick();
    check_eq("rs_done2", a_out_done, 0);
    check_eq("rs_active2", a_out_active, 0);
    rst = 1'b0;
    #1;
    check_eq("rs_ready_after", a_if.in_data_ready, 1);
    run_msg(m4, 1'b0, rx, act_cycles, act_first, done_at, done_cnt, ready_at, gap_bad);
    check_msg("after_rs", m4, rx, act_cycles, act_first, done_at, done_cnt, ready_at, gap_bad);

    // Reset during GAP truncates the gap
    a_if.in_data = m0; a_if.in_data_valid = 1'b1;
    tick();
    a_if.in_data_valid = 1'b0;
    repeat (139) tick();  // cycle 140: inside gap (129..160)
    check_eq("gap_ready", a_if.in_data_ready, 0);
    check_eq("gap_active", a_out_active, 0);
    rst = 1'b1;
    tick();
    check_eq("rg_ready_in_rst", a_if.in_data_ready, 0);
    check_eq("rg_data", a_out_data, 0);
    rst = 1'b0;
    #1;
    check_eq("rg_ready_after", a_if.in_data_ready, 1);
    run_msg(m1, 1'b0, rx, act_cycles, act_first, done_at, done_cnt, ready_at, gap_bad);
    check_msg("after_rg", m1, rx, act_cycles, act_first, done_at, done_cnt, ready_at, gap_bad);

    // GAP = 0, WIDTH = 8, valid held high
    hs_vec = '0; act_vec = '0; done_vec = '0; rx1 = '0; rx2 = '0;
    b_if.in_data_valid = 1'b1;
    for (int c = 0; c < 36; c++) begin
      b_if.in_data = (c < 9) ? 8'hA5 : 8'h3C;
      #0;
      hs_vec[c]   = b_if.in_data_ready && b_if.in_data_valid;
      act_vec[c]  = b_out_active;
      done_vec[c] = b_out_done;
      if (c >= 1 && c <= 8)   rx1 = {b_out_data, rx1[7:1]};
      if (c >= 10 && c <= 17) rx2 = {b_out_data, rx2[7:1]};
      tick();
    end
    b_if.in_data_valid = 1'b0;
    for (int c = 0; c < 36; c++) begin
      hs_exp[c]   = (c % 9) == 0;
      act_exp[c]  = (c % 9) != 0;
      done_exp[c] = (c >= 9) && ((c % 9) == 0);
    end
    check_eq("g0_handshakes", hs_vec, hs_exp);
    check_eq("g0_active", act_vec, act_exp);
    check_eq("g0_done", done_vec, done_exp);
    check_eq("g0_msg1", rx1, 8'hA5);
    check_eq("g0_msg2", rx2, 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
